// File: rtl/arb_pkg.sv
// Shared definitions for the two-way priority arbiter and its requester clients.
package arb_pkg;

    localparam int PRIO_W = 2;
    localparam logic [PRIO_W-1:0] PRIO_MAX = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    // Width needed to count 0..n-1, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_prio_ager.sv
// Aging priority: counts waiting cycles and bumps a saturating priority every AGE_CYCLES.
module arb_prio_ager
    import arb_pkg::*;
#(
    parameter int                AGE_CYCLES = 8,
    parameter logic [PRIO_W-1:0] BASE_PRIO  = 2'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic              restart,
    input  logic              clear,
    output logic [PRIO_W-1:0] prio
);

    localparam int AGE_W = cnt_w(AGE_CYCLES);

    logic [AGE_W-1:0] age_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_cnt <= '0;
            prio    <= '0;
        end else if (clear) begin
            age_cnt <= '0;
            prio    <= '0;
        end else if (load) begin
            age_cnt <= '0;
            prio    <= BASE_PRIO;
        end else if (restart) begin
            age_cnt <= '0;
        end else if (en) begin
            if (age_cnt == AGE_W'(AGE_CYCLES - 1)) begin
                age_cnt <= '0;
                if (prio != PRIO_MAX) prio <= prio + PRIO_W'(1);
            end else begin
                age_cnt <= age_cnt + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: takes an N-beat job, requests with aging priority, drives bus_en
// for N granted beats, tolerates preemption, and always releases for one GAP cycle.
module arb_requester
    import arb_pkg::*;
#(
    parameter int                LEN_W      = 4,
    parameter logic [PRIO_W-1:0] BASE_PRIO  = 2'd0,
    parameter int                AGE_CYCLES = 8,
    parameter int                MAX_WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    input  logic [LEN_W-1:0]  job_len,
    output logic              job_ready,
    output logic              req,
    output logic [PRIO_W-1:0] prio,
    input  logic              grant,
    output logic              bus_en,
    output logic              done,
    output logic              timeout
);

    localparam int BEATS_W = LEN_W + 1;
    localparam int WAIT_W  = cnt_w(MAX_WAIT);
    localparam logic [BEATS_W-1:0] BEAT_ONE = BEATS_W'(1);

    arb_state_t         state;
    logic [BEATS_W-1:0] beats_left;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_hit;
    logic               last_beat;
    logic               ager_load;
    logic               ager_en;
    logic               ager_restart;
    logic               ager_clear;

    assign job_ready = (state == IDLE);
    assign wait_hit  = (MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign last_beat = (beats_left == BEAT_ONE);

    assign ager_load    = (state == IDLE) && job_valid;
    assign ager_en      = (state == REQ) && !grant;
    assign ager_restart = (state == HOLD) && !grant;
    // Priority drops to zero on the same edge that enters GAP.
    assign ager_clear   = ((state == REQ) && !grant && wait_hit) ||
                          ((state == HOLD) && grant && last_beat);

    arb_prio_ager #(
        .AGE_CYCLES (AGE_CYCLES),
        .BASE_PRIO  (BASE_PRIO)
    ) u_ager (
        .clk     (clk),
        .rst     (rst),
        .load    (ager_load),
        .en      (ager_en),
        .restart (ager_restart),
        .clear   (ager_clear),
        .prio    (prio)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req        <= 1'b0;
            bus_en     <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            beats_left <= '0;
            wait_cnt   <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        beats_left <= {1'b0, job_len} + BEAT_ONE;
                        wait_cnt   <= '0;
                        req        <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (grant) begin
                        bus_en <= 1'b1;
                        state  <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_hit) begin
                            timeout <= 1'b1;
                            req     <= 1'b0;
                            state   <= GAP;
                        end
                    end
                end
                HOLD: begin
                    // A beat only counts when the grant is still held at the edge.
                    if (!grant) begin
                        bus_en <= 1'b0;
                        state  <= REQ;
                    end else begin
                        beats_left <= beats_left - BEAT_ONE;
                        if (last_beat) begin
                            done   <= 1'b1;
                            req    <= 1'b0;
                            bus_en <= 1'b0;
                            state  <= GAP;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: three instances cover default, aging and timeout builds.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_job_valid = 1'b0, a_grant = 1'b0;
    logic [3:0] a_job_len = 4'd0;
    logic       a_job_ready, a_req, a_bus_en, a_done, a_timeout;
    logic [1:0] a_prio;

    logic       b_job_valid = 1'b0, b_grant = 1'b0;
    logic [3:0] b_job_len = 4'd0;
    logic       b_job_ready, b_req, b_bus_en, b_done, b_timeout;
    logic [1:0] b_prio;

    logic       c_job_valid = 1'b0, c_grant = 1'b0;
    logic [3:0] c_job_len = 4'd0;
    logic       c_job_ready, c_req, c_bus_en, c_done, c_timeout;
    logic [1:0] c_prio;

    int errors = 0;
    int checks = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int jobs_pushed = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    arb_requester dut_a (
        .clk(clk), .rst(rst), .job_valid(a_job_valid), .job_len(a_job_len),
        .job_ready(a_job_ready), .req(a_req), .prio(a_prio), .grant(a_grant),
        .bus_en(a_bus_en), .done(a_done), .timeout(a_timeout)
    );

    arb_requester #(.AGE_CYCLES(4), .BASE_PRIO(2'd1)) dut_b (
        .clk(clk), .rst(rst), .job_valid(b_job_valid), .job_len(b_job_len),
        .job_ready(b_job_ready), .req(b_req), .prio(b_prio), .grant(b_grant),
        .bus_en(b_bus_en), .done(b_done), .timeout(b_timeout)
    );

    arb_requester #(.MAX_WAIT(10)) dut_c (
        .clk(clk), .rst(rst), .job_valid(c_job_valid), .job_len(c_job_len),
        .job_ready(c_job_ready), .req(c_req), .prio(c_prio), .grant(c_grant),
        .bus_en(c_bus_en), .done(c_done), .timeout(c_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int beats);
        exp_q.push_back(beats);
        jobs_pushed++;
    endtask

    // Scoreboard for dut_a: counts granted beats, pops the expected beat count at each done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                beat_cnt = 0;
            end else begin
                if (a_bus_en && a_grant) beat_cnt++;
                if (a_done) begin
                    done_cnt++;
                    chk("sb_done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("sb_beats", beat_cnt, exp_q.pop_front());
                    chk("sb_done_req_low", a_req, 0);
                    beat_cnt = 0;
                end
            end
        end
    end

    logic [2:0] basic_exp [5] = '{3'b110, 3'b110, 3'b110, 3'b001, 3'b000};
    logic       pre_g     [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] b2b_pat   [4] = '{3'b100, 3'b110, 3'b001, 3'b000};

    initial begin
        int exp_prio;

        // Reset and release
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_a", {a_job_ready, a_req, a_prio, a_bus_en, a_done, a_timeout}, 7'b1000000);
        chk("rst_b", {b_job_ready, b_req, b_prio, b_bus_en, b_done, b_timeout}, 7'b1000000);
        chk("rst_c", {c_job_ready, c_req, c_prio, c_bus_en, c_done, c_timeout}, 7'b1000000);

        // Async reset mid-job with job_valid still high
        a_job_len = 4'd3;
        a_job_valid = 1'b1;
        tick();
        chk("accept_req", a_req, 1);
        chk("accept_not_ready", a_job_ready, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {a_job_ready, a_req, a_prio, a_bus_en, a_done, a_timeout}, 7'b1000000);
        tick();
        a_job_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_release_idle", {a_job_ready, a_req, a_bus_en, a_done}, 4'b1000);

        // Basic job: 3 beats, grant two cycles after req rises
        a_job_len = 4'd2;
        a_job_valid = 1'b1;
        push_job(3);
        tick();
        a_job_valid = 1'b0;
        chk("basic_req_rise", a_req, 1);
        tick();
        chk("basic_wait_no_bus", {a_req, a_bus_en}, 2'b10);
        a_grant = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("basic_seq%0d", i), {a_req, a_bus_en, a_done}, basic_exp[i]);
            if (i == 3) a_grant = 1'b0;
            tick();
        end
        chk("basic_ready", a_job_ready, 1);

        // Preemption: 5 beats, grant lost for 3 cycles after 2 beats
        a_job_len = 4'd4;
        a_job_valid = 1'b1;
        push_job(5);
        tick();
        a_job_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_grant = pre_g[i];
            chk($sformatf("pre_req%0d", i), a_req, 1);
            chk($sformatf("pre_prio%0d", i), a_prio, 0);
            tick();
        end
        a_grant = 1'b0;
        chk("pre_done", {a_req, a_bus_en, a_done}, 3'b001);
        tick();
        chk("pre_idle", {a_job_ready, a_done}, 2'b10);

        // Back-to-back single-beat jobs with job_valid held
        a_job_len = 4'd0;
        a_job_valid = 1'b1;
        a_grant = 1'b1;
        repeat (3) push_job(1);
        tick();
        for (int k = 0; k < 12; k++) begin
            if (k == 8) a_job_valid = 1'b0;
            chk($sformatf("b2b%0d", k), {a_req, a_bus_en, a_done}, b2b_pat[k % 4]);
            tick();
        end
        a_grant = 1'b0;

        // Aging on dut_b: prio 1 -> 2 -> 3 every 4 waiting cycles, then saturates
        b_job_valid = 1'b1;
        tick();
        b_job_valid = 1'b0;
        for (int n = 0; n < 14; n++) begin
            exp_prio = 1 + n / 4;
            if (exp_prio > 3) exp_prio = 3;
            chk($sformatf("age_prio%0d", n), b_prio, exp_prio);
            tick();
        end
        chk("age_req_held", b_req, 1);
        b_grant = 1'b1;
        repeat (2) tick();
        b_grant = 1'b0;
        chk("age_done", b_done, 1);
        tick();
        chk("age_idle_prio", {b_job_ready, b_prio}, 3'b100);

        // Timeout on dut_c: exactly 10 cycles after req rises
        c_job_valid = 1'b1;
        tick();
        c_job_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("to_wait%0d", n), {c_req, c_timeout}, 2'b10);
            tick();
        end
        chk("to_pulse", {c_req, c_timeout, c_done, c_bus_en}, 4'b0100);
        tick();
        chk("to_idle", {c_job_ready, c_timeout, c_done}, 3'b100);

        // Grant on the timeout edge wins
        c_job_valid = 1'b1;
        tick();
        c_job_valid = 1'b0;
        repeat (9) tick();
        c_grant = 1'b1;
        tick();
        chk("to_grant_wins", {c_req, c_bus_en, c_timeout}, 3'b110);
        tick();
        c_grant = 1'b0;
        chk("to_grant_done", {c_req, c_done, c_timeout}, 3'b010);
        tick();

        chk("sb_drained", exp_q.size(), 0);
        chk("sb_done_count", done_cnt, jobs_pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
